// File: rtl/multichannel_conv_combiner_if.sv
// -----------------------------------------------------------------------------
// multichannel_conv_combiner_if
//
// Bundles the partial-sum input beat and the combined pixel output of
// multichannel_conv_combiner.
//
//   psum_in    CH*PSUM_W  signed partial sums, channel c at [c*PSUM_W +: PSUM_W]
//   psum_valid 1          one column beat offered this cycle
//   sof        1          start of frame, qualified by psum_valid
//   bias_in    OUT_W      signed bias for the beat
//   relu_en    1          ReLU enable for the beat
//   conv_out   OUT_W      signed combined pixel
//   conv_valid 1          conv_out holds a valid pixel
//   row_last   1          pixel is the last of its output row
//   frame_done 1          pixel is the last of the frame
//   overflow   1          sticky saturation flag, cleared by sof
//
// master: the upstream side (systolic arrays / bench); slave: the combiner.
// -----------------------------------------------------------------------------
interface multichannel_conv_combiner_if #(
   parameter int CH     = 3,
   parameter int PSUM_W = 20,
   parameter int OUT_W  = 24
);
   logic        [CH*PSUM_W-1:0] psum_in;
   logic                        psum_valid;
   logic                        sof;
   logic signed [OUT_W-1:0]     bias_in;
   logic                        relu_en;
   logic signed [OUT_W-1:0]     conv_out;
   logic                        conv_valid;
   logic                        row_last;
   logic                        frame_done;
   logic                        overflow;

   modport master (
      output psum_in, psum_valid, sof, bias_in, relu_en,
      input  conv_out, conv_valid, row_last, frame_done, overflow
   );

   modport slave (
      input  psum_in, psum_valid, sof, bias_in, relu_en,
      output conv_out, conv_valid, row_last, frame_done, overflow
   );
endinterface

// File: rtl/multichannel_conv_combiner.sv
// -----------------------------------------------------------------------------
// multichannel_conv_combiner
//
// Sums the CH per-channel convolution partial sums of one column beat, adds a
// signed bias, saturates to OUT_W bits, optionally applies ReLU and registers
// the pixel. A (row, col) tracker marks which beats correspond to kernel
// windows lying fully inside the IMG_W x IMG_H image; only those produce a
// valid output pixel. Latency from accepted beat to conv_valid is 2 cycles,
// there is no backpressure.
//
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  multichannel_conv_combiner_if.slave (beat inputs, pixel outputs)
// -----------------------------------------------------------------------------
module multichannel_conv_combiner #(
   parameter int CH     = 3,
   parameter int PSUM_W = 20,
   parameter int OUT_W  = 24,
   parameter int KERNEL = 3,
   parameter int IMG_W  = 224,
   parameter int IMG_H  = 224
) (
   input  logic                         clk,
   input  logic                         rst,
   multichannel_conv_combiner_if.slave  bus
);

   localparam int SUM_W = PSUM_W + $clog2(CH);
   localparam int ACC_W = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;
   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
   localparam logic [COL_W-1:0] COL_K    = COL_W'(KERNEL - 1);
   localparam logic [ROW_W-1:0] ROW_K    = ROW_W'(KERNEL - 1);

   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   // With a 1x1 kernel every row is already a full window row.
   localparam state_t START_STATE = (KERNEL == 1) ? RUN : FILL;

   // --------------------------------------------------------------------------
   // Arithmetic helpers
   // --------------------------------------------------------------------------
   function automatic logic sat_clips(input logic signed [ACC_W-1:0] v);
      return (v > SAT_MAX) || (v < SAT_MIN);
   endfunction

   function automatic logic signed [OUT_W-1:0] saturate(
      input logic signed [ACC_W-1:0] v);
      if (v > SAT_MAX)
         return SAT_MAX[OUT_W-1:0];
      else if (v < SAT_MIN)
         return SAT_MIN[OUT_W-1:0];
      else
         return v[OUT_W-1:0];
   endfunction

   function automatic logic signed [OUT_W-1:0] relu(
      input logic signed [OUT_W-1:0] v,
      input logic                    en);
      return (en && v[OUT_W-1]) ? '0 : v;
   endfunction

   // --------------------------------------------------------------------------
   // Position tracker / FSM
   // --------------------------------------------------------------------------
   state_t           state, state_nxt, beat_state;
   logic [COL_W-1:0] col, col_nxt, pos_col;
   logic [ROW_W-1:0] row, row_nxt, pos_row;
   logic             sof_acc, beat_acc, last_col, last_row;
   logic             vld_p0, row_last_p0, frame_done_p0;

   always_comb begin
      sof_acc  = bus.psum_valid & bus.sof;
      // Outside a frame only a start-of-frame beat is accepted.
      beat_acc = bus.psum_valid & (bus.sof | (state != IDLE));

      // A sof beat is (0,0) of a fresh frame whatever the tracker held.
      pos_col    = sof_acc ? '0 : col;
      pos_row    = sof_acc ? '0 : row;
      beat_state = sof_acc ? START_STATE : state;

      last_col = (pos_col == COL_LAST);
      last_row = (pos_row == ROW_LAST);

      vld_p0        = beat_acc && (beat_state == RUN) && (pos_col >= COL_K);
      row_last_p0   = vld_p0 && last_col;
      frame_done_p0 = row_last_p0 && last_row;

      state_nxt = state;
      col_nxt   = col;
      row_nxt   = row;
      if (beat_acc) begin
         state_nxt = beat_state;
         col_nxt   = pos_col + 1'b1;
         row_nxt   = pos_row;
         if (last_col) begin
            col_nxt = '0;
            row_nxt = pos_row + 1'b1;
            if ((beat_state == FILL) && (row_nxt == ROW_K))
               state_nxt = RUN;
            if ((beat_state == RUN) && last_row) begin
               state_nxt = IDLE;
               row_nxt   = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         col   <= '0;
         row   <= '0;
      end else begin
         state <= state_nxt;
         col   <= col_nxt;
         row   <= row_nxt;
      end
   end

   // --------------------------------------------------------------------------
   // Stage 0 -> 1: channel sum
   // --------------------------------------------------------------------------
   logic signed [PSUM_W-1:0] ch_p0;
   logic signed [SUM_W-1:0]  sum_p0;

   always_comb begin
      ch_p0  = '0;
      sum_p0 = '0;
      for (int c = 0; c < CH; c++) begin
         ch_p0  = bus.psum_in[c*PSUM_W +: PSUM_W];
         // Size cast of a signed operand sign-extends each channel.
         sum_p0 = sum_p0 + SUM_W'(ch_p0);
      end
   end

   logic signed [SUM_W-1:0] sum_p1;
   logic signed [OUT_W-1:0] bias_p1;
   logic                    relu_p1;
   logic                    vld_p1, row_last_p1, frame_done_p1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1        <= 1'b0;
         row_last_p1   <= 1'b0;
         frame_done_p1 <= 1'b0;
      end else begin
         vld_p1        <= vld_p0;
         row_last_p1   <= row_last_p0;
         frame_done_p1 <= frame_done_p0;
      end
   end

   // Bias and ReLU travel with the beat so each pixel uses its own settings.
   always_ff @(posedge clk) begin
      sum_p1  <= sum_p0;
      bias_p1 <= bus.bias_in;
      relu_p1 <= bus.relu_en;
   end

   // --------------------------------------------------------------------------
   // Stage 1 -> 2: bias, saturation, ReLU
   // --------------------------------------------------------------------------
   logic signed [ACC_W-1:0] acc_p1;
   logic signed [OUT_W-1:0] res_p1;
   logic                    clip_p1;

   always_comb begin
      acc_p1  = ACC_W'(sum_p1) + ACC_W'(bias_p1);
      clip_p1 = sat_clips(acc_p1);
      res_p1  = relu(saturate(acc_p1), relu_p1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.conv_out   <= '0;
         bus.conv_valid <= 1'b0;
         bus.row_last   <= 1'b0;
         bus.frame_done <= 1'b0;
         bus.overflow   <= 1'b0;
      end else begin
         bus.conv_valid <= vld_p1;
         bus.row_last   <= row_last_p1;
         bus.frame_done <= frame_done_p1;
         if (vld_p1)
            bus.conv_out <= res_p1;
         // A new frame starts with a clean flag; a clip from a pixel of the
         // previous frame landing on that same cycle is not carried over.
         if (sof_acc)
            bus.overflow <= 1'b0;
         else if (vld_p1 && clip_p1)
            bus.overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_multichannel_conv_combiner.sv
// -----------------------------------------------------------------------------
// tb_multichannel_conv_combiner
//
// Two instances on a 6x5 image, 3x3 kernel, 3 channels: dut_a with 24-bit
// output, dut_b with 8-bit output. Both receive identical beats.
// -----------------------------------------------------------------------------
module tb_multichannel_conv_combiner;

   localparam int IW = 6;
   localparam int IH = 5;
   localparam int K  = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   multichannel_conv_combiner_if #(.CH(3), .PSUM_W(20), .OUT_W(24)) if_a ();
   multichannel_conv_combiner_if #(.CH(3), .PSUM_W(20), .OUT_W(8))  if_b ();

   multichannel_conv_combiner #(
      .CH(3), .PSUM_W(20), .OUT_W(24), .KERNEL(K), .IMG_W(IW), .IMG_H(IH)
   ) dut_a (
      .clk(clk),
      .rst(rst),
      .bus(if_a.slave)
   );

   multichannel_conv_combiner #(
      .CH(3), .PSUM_W(20), .OUT_W(8), .KERNEL(K), .IMG_W(IW), .IMG_H(IH)
   ) dut_b (
      .clk(clk),
      .rst(rst),
      .bus(if_b.slave)
   );

   typedef struct {
      int p0, p1, p2;
      int bias;
      bit relu;
      int exp_a;
      int exp_b;
   } vec_t;

   vec_t tbl[12];

   int checks = 0;
   int errors = 0;

   int qa_val[$];
   int qa_cyc[$];
   bit qa_rl[$];
   bit qa_fd[$];
   int qb_val[$];
   int bc[$];

   always @(negedge clk) begin
      if (if_a.conv_valid) begin
         qa_val.push_back(int'(if_a.conv_out));
         qa_cyc.push_back(cyc);
         qa_rl.push_back(if_a.row_last);
         qa_fd.push_back(if_a.frame_done);
      end
      if (if_b.conv_valid)
         qb_val.push_back(int'(if_b.conv_out));
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
      end
   endtask

   task automatic clr();
      qa_val.delete();
      qa_cyc.delete();
      qa_rl.delete();
      qa_fd.delete();
      qb_val.delete();
      bc.delete();
   endtask

   task automatic drive(input bit v, input bit s, input int p0, input int p1,
                        input int p2, input int bias, input bit relu);
      if_a.psum_valid = v;
      if_a.sof        = s;
      if_a.psum_in    = {20'(p2), 20'(p1), 20'(p0)};
      if_a.bias_in    = 24'(bias);
      if_a.relu_en    = relu;
      if_b.psum_valid = v;
      if_b.sof        = s;
      if_b.psum_in    = {20'(p2), 20'(p1), 20'(p0)};
      if_b.bias_in    = 8'(bias);
      if_b.relu_en    = relu;
   endtask

   // One cycle: inputs change on the falling edge and are captured on the next rising edge.
   task automatic beat(input bit v, input bit s, input int p0, input int p1,
                       input int p2, input int bias, input bit relu);
      @(negedge clk);
      drive(v, s, p0, p1, p2, bias, relu);
      if (v)
         bc.push_back(cyc);
   endtask

   task automatic idle(input int n);
      repeat (n) beat(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
   endtask

   // Expected layout of one full 6x5 frame: productive beats are rows 2..4,
   // columns 2..5, each emerging 2 cycles after its beat.
   task automatic check_frame(input string tag, input int val);
      int k;
      chk({tag, "_count_a"}, qa_val.size(), 12);
      chk({tag, "_count_b"}, qb_val.size(), 12);
      k = 0;
      for (int r = K - 1; r < IH; r++) begin
         for (int c = K - 1; c < IW; c++) begin
            if (k < qa_val.size() && (r * IW + c) < bc.size()) begin
               chk($sformatf("%s_val%0d", tag, k), qa_val[k], val);
               chk($sformatf("%s_lat%0d", tag, k), qa_cyc[k], bc[r * IW + c] + 2);
               chk($sformatf("%s_rowlast%0d", tag, k), int'(qa_rl[k]), int'(c == IW - 1));
               chk($sformatf("%s_fdone%0d", tag, k), int'(qa_fd[k]),
                   int'((r == IH - 1) && (c == IW - 1)));
            end
            k++;
         end
      end
   endtask

   initial begin
      int k, n_fd, n_rl;

      //            p0       p1       p2       bias      relu exp_a     exp_b
      tbl[0]  = '{-5,      -5,      -5,       4,        1'b0, -11,      -11};
      tbl[1]  = '{-5,      -5,      -5,       4,        1'b1, 0,        0};
      tbl[2]  = '{-5,      -5,      -5,       4,        1'b0, -11,      -11};
      tbl[3]  = '{-5,      -5,      -5,       4,        1'b1, 0,        0};
      tbl[4]  = '{1,       1,       1,        0,        1'b0, 3,        3};
      tbl[5]  = '{100,     100,     100,      0,        1'b0, 300,      127};
      tbl[6]  = '{-100,    -100,    -100,     0,        1'b0, -300,     -128};
      tbl[7]  = '{-100,    -100,    -100,     0,        1'b1, 0,        0};
      tbl[8]  = '{50,      50,      50,       -100,     1'b0, 50,       50};
      tbl[9]  = '{-7,      3,       2,        10,       1'b1, 8,        8};
      tbl[10] = '{524287,  524287,  524287,   0,        1'b0, 1572861,  127};
      tbl[11] = '{-524288, -524288, -524288,  -8388608, 1'b0, -8388608, -128};

      // Reset state
      drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_valid_a",  int'(if_a.conv_valid), 0);
      chk("rst_out_a",    int'(if_a.conv_out),   0);
      chk("rst_rowlast_a", int'(if_a.row_last),  0);
      chk("rst_fdone_a",  int'(if_a.frame_done), 0);
      chk("rst_ovf_a",    int'(if_a.overflow),   0);
      chk("rst_valid_b",  int'(if_b.conv_valid), 0);
      chk("rst_out_b",    int'(if_b.conv_out),   0);
      rst = 1'b0;

      // Contiguous frame of all-ones partial sums
      clr();
      for (int i = 0; i < IW * IH; i++)
         beat(1'b1, i == 0, 1, 1, 1, 0, 1'b0);
      idle(4);
      check_frame("contig", 3);

      // Same frame with a bubble after every beat; sof is raised during the
      // bubbles and must be ignored there.
      clr();
      for (int i = 0; i < IW * IH; i++) begin
         beat(1'b1, i == 0, 1, 1, 1, 0, 1'b0);
         beat(1'b0, 1'b1, 9, 9, 9, 0, 1'b1);
      end
      idle(4);
      check_frame("bubble", 3);

      // Arithmetic vectors placed on the productive beats of one frame
      clr();
      k = 0;
      for (int i = 0; i < IW * IH; i++) begin
         if ((i / IW) >= K - 1 && (i % IW) >= K - 1) begin
            beat(1'b1, i == 0, tbl[k].p0, tbl[k].p1, tbl[k].p2, tbl[k].bias, tbl[k].relu);
            k++;
         end else begin
            beat(1'b1, i == 0, 0, 0, 0, 0, 1'b0);
         end
      end
      idle(4);
      chk("vec_count_a", qa_val.size(), 12);
      chk("vec_count_b", qb_val.size(), 12);
      for (int j = 0; j < 12; j++) begin
         if (j < qa_val.size())
            chk($sformatf("vec_a%0d", j), qa_val[j], tbl[j].exp_a);
         if (j < qb_val.size())
            chk($sformatf("vec_b%0d", j), qb_val[j], tbl[j].exp_b);
      end
      chk("vec_ovf_a", int'(if_a.overflow), 1);
      chk("vec_ovf_b", int'(if_b.overflow), 1);
      beat(1'b1, 1'b1, 0, 0, 0, 0, 1'b0);
      beat(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
      chk("sof_clr_ovf_a", int'(if_a.overflow), 0);
      chk("sof_clr_ovf_b", int'(if_b.overflow), 0);
      idle(2);

      // Frame restarted by sof at beat (3,1)
      clr();
      for (int i = 0; i < 3 * IW + 1; i++)
         beat(1'b1, i == 0, 1, 0, 0, 0, 1'b0);
      for (int i = 0; i < IW * IH; i++)
         beat(1'b1, i == 0, 2, 0, 0, 0, 1'b0);
      idle(4);
      chk("restart_count", qa_val.size(), 16);
      n_fd = 0;
      n_rl = 0;
      for (int j = 0; j < qa_val.size(); j++) begin
         chk($sformatf("restart_val%0d", j), qa_val[j], (j < 4) ? 1 : 2);
         n_fd += int'(qa_fd[j]);
         n_rl += int'(qa_rl[j]);
      end
      chk("restart_fdone_count", n_fd, 1);
      chk("restart_rowlast_count", n_rl, 4);
      if (qa_fd.size() == 16)
         chk("restart_fdone_last", int'(qa_fd[15]), 1);

      // Reset one cycle after a productive beat
      clr();
      for (int i = 0; i < 2 * IW + 3; i++)
         beat(1'b1, i == 0, 1, 1, 1, 0, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
      rst = 1'b1;
      #1;
      chk("midrst_valid_a",  int'(if_a.conv_valid), 0);
      chk("midrst_out_a",    int'(if_a.conv_out),   0);
      chk("midrst_rowlast_a", int'(if_a.row_last),  0);
      chk("midrst_fdone_a",  int'(if_a.frame_done), 0);
      chk("midrst_out_b",    int'(if_b.conv_out),   0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      // Beats without sof after reset belong to no frame.
      for (int i = 0; i < IW * IH; i++)
         beat(1'b1, 1'b0, 1, 1, 1, 0, 1'b0);
      idle(4);
      chk("midrst_no_pulse", qa_val.size(), 0);

      // A fresh frame after reset
      clr();
      for (int i = 0; i < IW * IH; i++)
         beat(1'b1, i == 0, 0, 0, 1, 5, 1'b0);
      idle(4);
      chk("post_rst_count", qa_val.size(), 12);
      if (qa_val.size() > 0)
         chk("post_rst_val0", qa_val[0], 6);
      if (qa_fd.size() == 12)
         chk("post_rst_fdone", int'(qa_fd[11]), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
